maxpool_2x2: RTL

Streaming 2×2, stride-2 max-pooling stage for three feature-map channels, placed directly downstream of the ReLU activation stage. It accepts one pixel per channel per `valid_in` beat in raster order and emits one pooled pixel per channel for every 2×2 window. A half-width line buffer holds the horizontal maxima of the even row; the odd row completes each window. Output feeds the next convolution layer or the flatten/FC input buffer.

---
 rtl/maxpool_2x2_if.sv | 30 +++
 rtl/maxpool_2x2.sv | 114 +++++++++++
 2 files changed

// File: rtl/maxpool_2x2_if.sv
// maxpool_2x2_if
//   Streaming link around the 2x2 max-pooling stage.
//   Upstream side : valid_in, relu_in_1..3 (one pixel per channel per beat)
//   Downstream side: pool_out_1..3, valid_out, frame_done
//   Modports:
//     master - the stream producer / consumer around the pooling stage
//     slave  - the pooling stage itself
interface maxpool_2x2_if #(
    parameter int CONV_BIT = 12
);
    logic                valid_in;
    logic [CONV_BIT-1:0] relu_in_1;
    logic [CONV_BIT-1:0] relu_in_2;
    logic [CONV_BIT-1:0] relu_in_3;
    logic [CONV_BIT-1:0] pool_out_1;
    logic [CONV_BIT-1:0] pool_out_2;
    logic [CONV_BIT-1:0] pool_out_3;
    logic                valid_out;
    logic                frame_done;

    modport master (
        output valid_in, relu_in_1, relu_in_2, relu_in_3,
        input  pool_out_1, pool_out_2, pool_out_3, valid_out, frame_done
    );

    modport slave (
        input  valid_in, relu_in_1, relu_in_2, relu_in_3,
        output pool_out_1, pool_out_2, pool_out_3, valid_out, frame_done
    );
endinterface

// File: rtl/maxpool_2x2.sv
// maxpool_2x2
//   Streaming 2x2 / stride-2 max pooling over three channels. Pixels arrive
//   in raster order, one per channel per valid_in beat. Each pair of pixels
//   in a row is reduced to a horizontal max; on even rows that max is parked
//   in a half-width line buffer, on odd rows it is combined with the parked
//   value to finish the window.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - maxpool_2x2_if.slave (valid_in, relu_in_1..3 in;
//             pool_out_1..3, valid_out, frame_done out, all registered)
module maxpool_2x2 #(
    parameter int CONV_BIT  = 12,
    parameter int IN_WIDTH  = 24,
    parameter int IN_HEIGHT = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    maxpool_2x2_if.slave  bus
);
    localparam int COL_W  = (IN_WIDTH  > 2) ? $clog2(IN_WIDTH)  : 1;
    localparam int ROW_W  = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
    localparam int HALF_W = IN_WIDTH / 2;
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic             last_col, last_row;
    logic             odd_col, odd_row;
    logic             fire;
    logic [LB_AW-1:0] lb_addr;
    logic             valid_out_reg;
    logic             frame_done_reg;

    logic [CONV_BIT-1:0] pix [3];

    assign pix[0] = bus.relu_in_1;
    assign pix[1] = bus.relu_in_2;
    assign pix[2] = bus.relu_in_3;

    assign last_col = (col_reg == COL_W'(IN_WIDTH - 1));
    assign last_row = (row_reg == ROW_W'(IN_HEIGHT - 1));
    assign odd_col  = col_reg[0];
    assign odd_row  = row_reg[0];
    assign lb_addr  = LB_AW'(col_reg >> 1);
    // Bottom-right pixel of a window: complete the pool this beat.
    assign fire     = bus.valid_in & odd_col & odd_row;

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (bus.valid_in) begin
            if (last_col) begin
                col_next = '0;
                row_next = last_row ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg        <= '0;
            row_reg        <= '0;
            valid_out_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            valid_out_reg  <= fire;
            frame_done_reg <= bus.valid_in & last_col & last_row;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_ch
            logic [CONV_BIT-1:0] hold_reg;
            logic [CONV_BIT-1:0] linebuf [0:HALF_W-1];
            logic [CONV_BIT-1:0] pool_reg;
            logic [CONV_BIT-1:0] hmax;
            logic [CONV_BIT-1:0] lb_rd;
            logic [CONV_BIT-1:0] pooled;

            assign hmax   = (pix[gi] > hold_reg) ? pix[gi] : hold_reg;
            // Even-row entries are written on even rows and read only on odd
            // rows, so the read never collides with a write to the same slot.
            assign lb_rd  = linebuf[lb_addr];
            assign pooled = (hmax > lb_rd) ? hmax : lb_rd;

            // Data path storage: always written before it is read, so no reset.
            always_ff @(posedge clk) begin
                if (bus.valid_in && !odd_col)
                    hold_reg <= pix[gi];
                if (bus.valid_in && odd_col && !odd_row)
                    linebuf[lb_addr] <= hmax;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    pool_reg <= '0;
                else if (fire)
                    pool_reg <= pooled;
            end
        end
    endgenerate

    assign bus.pool_out_1 = gen_ch[0].pool_reg;
    assign bus.pool_out_2 = gen_ch[1].pool_reg;
    assign bus.pool_out_3 = gen_ch[2].pool_reg;
    assign bus.valid_out  = valid_out_reg;
    assign bus.frame_done = frame_done_reg;
endmodule
